sod_frame_scheduler: RTL and testbench
======================================

// Module: sod_frame_scheduler
// PURPOSE
//  Sequences one shared stuff_or_data datapath among NUM_CH frame requesters.
//  Round-robin arbitration picks a channel; the block presents its pm/cm with a 1-cycle sof, then issues pm valid beats gated by slot_en.
//  It collects ds from the datapath, counts data and stuff beats, and reports completion per channel.
//  Sits between the channel framers and the stuff_or_data instance.
// PARAMETERS
//  MPT_W   8  width of pm/cm and of the beat counters
//  NUM_CH  4  requester count (>=2); CH_W = $clog2(NUM_CH)
// PORTS
//  clk        in   1            single clock, all logic on posedge
//  rst_n      in   1            synchronous, active-low reset
//  req        in   NUM_CH       per-channel frame request, level, held until gnt
//  pm_in      in   NUM_CH*MPT_W per-channel beats per frame, ch k at [k*MPT_W +: MPT_W]
//  cm_in      in   NUM_CH*MPT_W per-channel data beats per frame, same packing
//  slot_en    in   1            downstream slot available; gates beat issue
//  gnt        out  NUM_CH       one-hot, 1-cycle pulse when a channel's request is taken
//  done       out  NUM_CH       one-hot, 1-cycle pulse when that channel's frame completes
//  cfg_err    out  1            1-cycle pulse: granted request rejected (pm==0 or cm>pm)
//  busy       out  1            high in every state except IDLE
//  cur_ch     out  CH_W         channel currently owning the datapath
//  data_cnt   out  MPT_W        ds==1 beats in the last frame; valid with done
//  stuff_cnt  out  MPT_W        ds==0 beats in the last frame; valid with done
//  cnt_err    out  1            see CONFIGURATION
//  sod_pm     out  MPT_W        to datapath pm
//  sod_cm     out  MPT_W        to datapath cm
//  sod_sof    out  1            to datapath sof
//  sod_valid  out  1            to datapath valid_in
//  sod_vout   in   1            from datapath valid_out
//  sod_ds     in   1            from datapath ds
// BEHAVIOUR
//  Reset (rst_n==0 at posedge) values:
//  - all outputs 0; rr pointer 0; counters 0; state FLUSH.
//  - Reset wins over any in-flight frame; no done is issued for it.
//  FSM states: FLUSH, IDLE, LOAD, SOF, BURST, DRAIN, DONE.
//  - FLUSH: datapath has no reset, so it may be mid-frame.
//    - Drive sod_valid=1 and sod_sof=0.
//    - Go to IDLE on the first cycle (not the first FLUSH cycle) where sod_vout==0, or after 2^MPT_W+2 cycles.
//  - IDLE: if any req, round-robin grant starting at rr pointer.
//    - gnt pulse; latch pm/cm; cur_ch updated; rr pointer = granted+1 mod NUM_CH.
//    - Go to LOAD.
//  - LOAD: check latched values.
//    - pm==0 or cm>pm: cfg_err pulse, return to IDLE, no datapath activity.
//    - Otherwise go to SOF.
//  - SOF: sod_sof=1 for exactly 1 cycle; sod_pm/sod_cm hold latched values for the whole frame. Go to BURST.
//  - BURST: sod_valid = slot_en; issued counter increments on each sod_valid beat.
//    - On the beat where issued==pm: go to DRAIN.
//    - slot_en low: no beat issued, no progress; unbounded stall allowed.
//  - DRAIN: wait until the received count reaches pm, then go to DONE.
//  - Receive side (all states except FLUSH): each cycle with sod_vout==1 increments data_cnt if sod_ds, else stuff_cnt.
//    - Datapath latency is 1 cycle, so the last ds arrives 1 cycle after the last beat.
//  - DONE: done[cur_ch] pulse; data_cnt/stuff_cnt stable. Go to IDLE.
//    - Counters clear on the next grant.
//    - Next sof is never earlier than 2 cycles after the last beat, so the datapath is back in its fetch state.
//  Arithmetic and grant rules:
//  - Counters are MPT_W bits; pm<=2^MPT_W-1, so no wrap.
//  - stuff_cnt = pm - cm for a correct datapath.
//  - A request arriving while busy waits; gnt is never given to a channel with req==0.
//  - Simultaneous req from all channels: grants rotate ch0,1,2,3,0...
// CONFIGURATION
//  SOD_CNT_CHECK_EN defined:
//  - In DONE, cnt_err=1 (1-cycle, with done) if data_cnt!=cm or data_cnt+stuff_cnt!=pm.
//  - In BURST/DRAIN, sod_vout==1 on a cycle not following a sod_valid beat also sets cnt_err at DONE.
//  SOD_CNT_CHECK_EN undefined: cnt_err tied 0, check logic absent; all other behaviour identical.
// TESTING
//  - Reset: rst_n=0 3 cycles -> all outputs 0; FLUSH then IDLE within 2^MPT_W+2 cycles, busy=0.
//  - Single frame: ch1 pm=10, cm=7, slot_en=1 -> gnt[1]; sof 2 cycles later; 10 valid beats; done[1] with data_cnt=7, stuff_cnt=3.
//  - Round robin: req=4'b1111 held, pm=4, cm=2 each -> gnt order ch0,1,2,3,0; one done per gnt.
//  - Backpressure: pm=6, cm=6, slot_en toggling 1,0 -> exactly 6 sod_valid beats over 11 cycles; done with data_cnt=6, stuff_cnt=0.
//  - Config error: ch2 pm=0 -> cfg_err pulse, no sod_sof; ch3 pm=5, cm=9 -> cfg_err, no sod_sof.
//  - Mid-frame reset: rst_n low during beat 3 of pm=20 -> no done; FLUSH drains datapath; next frame pm=5, cm=2 gives data_cnt=2.
//    - With SOD_CNT_CHECK_EN, a forced wrong sod_ds -> cnt_err=1 with done.

Source files
------------

// File: rtl/sod_frame_scheduler.sv
// Round-robin frame scheduler sharing one stuff_or_data datapath among NUM_CH requesters.
// Define SOD_CNT_CHECK_EN to build the received-beat self-check that drives cnt_err.
module sod_frame_scheduler #(
  parameter int unsigned MPT_W  = 8,
  parameter int unsigned NUM_CH = 4,
  localparam int unsigned CH_W  = $clog2(NUM_CH)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NUM_CH-1:0]       req,
  input  logic [NUM_CH*MPT_W-1:0] pm_in,
  input  logic [NUM_CH*MPT_W-1:0] cm_in,
  input  logic                    slot_en,
  output logic [NUM_CH-1:0]       gnt,
  output logic [NUM_CH-1:0]       done,
  output logic                    cfg_err,
  output logic                    busy,
  output logic [CH_W-1:0]         cur_ch,
  output logic [MPT_W-1:0]        data_cnt,
  output logic [MPT_W-1:0]        stuff_cnt,
  output logic                    cnt_err,
  output logic [MPT_W-1:0]        sod_pm,
  output logic [MPT_W-1:0]        sod_cm,
  output logic                    sod_sof,
  output logic                    sod_valid,
  input  logic                    sod_vout,
  input  logic                    sod_ds
);

  localparam int unsigned FL_W = MPT_W + 2;
  localparam logic [FL_W-1:0] FLUSH_LAST = FL_W'((1 << MPT_W) + 1);

  typedef enum logic [2:0] {
    S_FLUSH,
    S_IDLE,
    S_LOAD,
    S_SOF,
    S_BURST,
    S_DRAIN,
    S_DONE
  } state_e;

  state_e             state_q, state_d;
  logic [CH_W-1:0]    rr_q, rr_d;
  logic [CH_W-1:0]    cur_q, cur_d;
  logic [MPT_W-1:0]   pm_q, pm_d;
  logic [MPT_W-1:0]   cm_q, cm_d;
  logic [MPT_W-1:0]   issued_q, issued_d;
  logic [MPT_W-1:0]   data_q, data_d;
  logic [MPT_W-1:0]   stuff_q, stuff_d;
  logic [FL_W-1:0]    flush_q, flush_d;
  logic [NUM_CH-1:0]  gnt_q, gnt_d;
  logic [NUM_CH-1:0]  done_q, done_d;
  logic               cfg_err_q, cfg_err_d;
  logic               busy_q, busy_d;
  logic               sof_q, sof_d;
  logic               valid_q, valid_d;

  logic               grant_found;
  logic [CH_W-1:0]    grant_idx;

  // Round-robin pick: first requesting channel at or after the rr pointer.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      if (!grant_found && req[CH_W'((32'(rr_q) + i) % NUM_CH)]) begin
        grant_found = 1'b1;
        grant_idx   = CH_W'((32'(rr_q) + i) % NUM_CH);
      end
    end
  end

  // Next-state and registered-output logic.
  always_comb begin
    state_d   = state_q;
    rr_d      = rr_q;
    cur_d     = cur_q;
    pm_d      = pm_q;
    cm_d      = cm_q;
    issued_d  = issued_q;
    data_d    = data_q;
    stuff_d   = stuff_q;
    flush_d   = flush_q;
    gnt_d     = '0;
    done_d    = '0;
    cfg_err_d = 1'b0;
    sof_d     = 1'b0;
    valid_d   = 1'b0;

    // Receive side: datapath output counted everywhere except while flushing.
    if (state_q != S_FLUSH && sod_vout) begin
      if (sod_ds) begin
        data_d = data_q + MPT_W'(1);
      end else begin
        stuff_d = stuff_q + MPT_W'(1);
      end
    end

    case (state_q)
      S_FLUSH: begin
        valid_d = 1'b1;
        flush_d = flush_q + FL_W'(1);
        if ((flush_q != '0 && !sod_vout) || flush_q == FLUSH_LAST) begin
          state_d = S_IDLE;
          valid_d = 1'b0;
          flush_d = '0;
        end
      end
      S_IDLE: begin
        if (grant_found) begin
          gnt_d[grant_idx] = 1'b1;
          cur_d    = grant_idx;
          pm_d     = pm_in[32'(grant_idx) * MPT_W +: MPT_W];
          cm_d     = cm_in[32'(grant_idx) * MPT_W +: MPT_W];
          rr_d     = (grant_idx == CH_W'(NUM_CH - 1)) ? '0 : grant_idx + CH_W'(1);
          issued_d = '0;
          data_d   = '0;
          stuff_d  = '0;
          state_d  = S_LOAD;
        end
      end
      S_LOAD: begin
        if (pm_q == '0 || cm_q > pm_q) begin
          cfg_err_d = 1'b1;
          state_d   = S_IDLE;
        end else begin
          state_d = S_SOF;
        end
      end
      S_SOF: begin
        sof_d   = 1'b1;
        state_d = S_BURST;
      end
      S_BURST: begin
        if (slot_en) begin
          valid_d  = 1'b1;
          issued_d = issued_q + MPT_W'(1);
          if (issued_q + MPT_W'(1) == pm_q) begin
            state_d = S_DRAIN;
          end
        end
      end
      S_DRAIN: begin
        if (MPT_W'(data_q + stuff_q) == pm_q) begin
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        done_d[cur_q] = 1'b1;
        state_d       = S_IDLE;
      end
      default: begin
        state_d = S_FLUSH;
      end
    endcase

    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= S_FLUSH;
      rr_q      <= '0;
      cur_q     <= '0;
      pm_q      <= '0;
      cm_q      <= '0;
      issued_q  <= '0;
      data_q    <= '0;
      stuff_q   <= '0;
      flush_q   <= '0;
      gnt_q     <= '0;
      done_q    <= '0;
      cfg_err_q <= 1'b0;
      busy_q    <= 1'b0;
      sof_q     <= 1'b0;
      valid_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      rr_q      <= rr_d;
      cur_q     <= cur_d;
      pm_q      <= pm_d;
      cm_q      <= cm_d;
      issued_q  <= issued_d;
      data_q    <= data_d;
      stuff_q   <= stuff_d;
      flush_q   <= flush_d;
      gnt_q     <= gnt_d;
      done_q    <= done_d;
      cfg_err_q <= cfg_err_d;
      busy_q    <= busy_d;
      sof_q     <= sof_d;
      valid_q   <= valid_d;
    end
  end

`ifdef SOD_CNT_CHECK_EN
  logic stray_q, stray_d;
  logic cnt_err_q, cnt_err_d;
  logic valid_dly_q;

  // A datapath output not preceded by an issued beat marks the frame as suspect.
  always_comb begin
    stray_d   = stray_q;
    cnt_err_d = 1'b0;
    if (state_q == S_IDLE && grant_found) begin
      stray_d = 1'b0;
    end else if ((state_q == S_BURST || state_q == S_DRAIN) && sod_vout && !valid_dly_q) begin
      stray_d = 1'b1;
    end
    if (state_q == S_DONE) begin
      cnt_err_d = stray_q || (data_q != cm_q) || (MPT_W'(data_q + stuff_q) != pm_q);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stray_q     <= 1'b0;
      cnt_err_q   <= 1'b0;
      valid_dly_q <= 1'b0;
    end else begin
      stray_q     <= stray_d;
      cnt_err_q   <= cnt_err_d;
      valid_dly_q <= valid_q;
    end
  end

  assign cnt_err = cnt_err_q;
`else
  assign cnt_err = 1'b0;
`endif

  assign gnt       = gnt_q;
  assign done      = done_q;
  assign cfg_err   = cfg_err_q;
  assign busy      = busy_q;
  assign cur_ch    = cur_q;
  assign data_cnt  = data_q;
  assign stuff_cnt = stuff_q;
  assign sod_pm    = pm_q;
  assign sod_cm    = cm_q;
  assign sod_sof   = sof_q;
  assign sod_valid = valid_q;

endmodule

// File: tb/tb_sod_frame_scheduler.sv
// Scoreboard bench for sod_frame_scheduler with a 1-cycle-latency datapath model.
module tb_sod_frame_scheduler;

  logic        clk;
  logic        rst_n;
  logic [3:0]  req;
  logic [31:0] pm_in;
  logic [31:0] cm_in;
  logic        slot_en;
  logic [3:0]  gnt;
  logic [3:0]  done;
  logic        cfg_err;
  logic        busy;
  logic [1:0]  cur_ch;
  logic [7:0]  data_cnt;
  logic [7:0]  stuff_cnt;
  logic        cnt_err;
  logic [7:0]  sod_pm;
  logic [7:0]  sod_cm;
  logic        sod_sof;
  logic        sod_valid;
  logic        sod_vout;
  logic        sod_ds;

  sod_frame_scheduler #(.MPT_W(8), .NUM_CH(4)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .pm_in(pm_in), .cm_in(cm_in),
    .slot_en(slot_en), .gnt(gnt), .done(done), .cfg_err(cfg_err), .busy(busy),
    .cur_ch(cur_ch), .data_cnt(data_cnt), .stuff_cnt(stuff_cnt), .cnt_err(cnt_err),
    .sod_pm(sod_pm), .sod_cm(sod_cm), .sod_sof(sod_sof), .sod_valid(sod_valid),
    .sod_vout(sod_vout), .sod_ds(sod_ds)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Datapath stand-in: no reset, data beats first (cm of them), then stuff.
  logic vout_m = 1'b0;
  logic ds_m = 1'b0;
  int   k_m = 0;
  int   cm_m = 0;
  bit   force_bad = 1'b0;
  always @(posedge clk) begin
    if (sod_sof) begin
      k_m  <= 0;
      cm_m <= int'(sod_cm);
    end
    vout_m <= sod_valid;
    if (sod_valid) begin
      ds_m <= (k_m < cm_m) ^ (force_bad && k_m == 0);
      k_m  <= k_m + 1;
    end
  end
  assign sod_vout = vout_m;
  assign sod_ds   = ds_m;

  typedef struct {
    int ch;
    int data;
    int stuff;
    int beats;
    int span;
    int cerr;
  } exp_t;

  exp_t exp_done_q[$];
  int   exp_gnt_q[$];
  int   exp_cfg_q[$];

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endfunction

  function automatic void unexpected(input string name, input int act);
    checks++;
    errors++;
    $display("FAIL %s: got %0d expected none", name, act);
  endfunction

  function automatic int oh2idx(input logic [3:0] v);
    int r;
    r = -1;
    if ($countones(v) == 1) begin
      for (int i = 0; i < 4; i++) if (v[i]) r = i;
    end
    return r;
  endfunction

  always @(posedge clk) cyc++;

  // Monitor: pops expectations whenever the DUT presents an event.
  int gnt_cyc = 0;
  int beats = 0;
  int sofs = 0;
  int first_beat = -1;
  int last_beat = -1;
  always @(negedge clk) begin
    exp_t e;
    int   g;
    if (sod_valid === 1'b1) begin
      beats++;
      if (first_beat < 0) first_beat = cyc;
      last_beat = cyc;
    end
    if (sod_sof === 1'b1) begin
      sofs++;
      chk("sof_latency", 32'(cyc - gnt_cyc), 32'd2);
    end
    if (gnt !== 4'b0000 && rst_n === 1'b1) begin
      if (exp_gnt_q.size() == 0) begin
        unexpected("gnt_unexpected", int'(gnt));
      end else begin
        g = exp_gnt_q.pop_front();
        chk("gnt_channel", 32'(oh2idx(gnt)), 32'(g));
      end
      gnt_cyc    = cyc;
      beats      = 0;
      sofs       = 0;
      first_beat = -1;
      last_beat  = -1;
    end
    if (done !== 4'b0000 && rst_n === 1'b1) begin
      if (exp_done_q.size() == 0) begin
        unexpected("done_unexpected", int'(done));
      end else begin
        e = exp_done_q.pop_front();
        chk("done_channel", 32'(oh2idx(done)), 32'(e.ch));
        chk("data_cnt", 32'(data_cnt), 32'(e.data));
        chk("stuff_cnt", 32'(stuff_cnt), 32'(e.stuff));
        chk("valid_beats", 32'(beats), 32'(e.beats));
        chk("beat_span", 32'(last_beat - first_beat + 1), 32'(e.span));
        chk("cnt_err_with_done", 32'(cnt_err), 32'(e.cerr));
      end
    end else if (cnt_err === 1'b1) begin
      unexpected("cnt_err_without_done", 1);
    end
    if (cfg_err === 1'b1) begin
      if (exp_cfg_q.size() == 0) begin
        unexpected("cfg_err_unexpected", int'(cur_ch));
      end else begin
        g = exp_cfg_q.pop_front();
        chk("cfg_err_channel", 32'(cur_ch), 32'(g));
        chk("cfg_err_no_sof", 32'(sofs), 32'd0);
        chk("cfg_err_no_beats", 32'(beats), 32'd0);
      end
    end
  end

  task automatic wait_idle(input string name);
    for (int i = 0; i < 300 && busy !== 1'b0; i++) @(negedge clk);
    chk(name, 32'(busy), 32'd0);
  endtask

  task automatic wait_drain(input string name);
    int pend;
    pend = 1;
    for (int i = 0; i < 2000 && pend != 0; i++) begin
      @(negedge clk);
      pend = exp_done_q.size() + exp_gnt_q.size() + exp_cfg_q.size();
    end
    chk(name, 32'(pend), 32'd0);
    repeat (3) @(negedge clk);
  endtask

  task automatic grant_one(input int ch);
    bit got;
    got = 1'b0;
    req[ch] = 1'b1;
    for (int i = 0; i < 50 && !got; i++) begin
      @(negedge clk);
      if (gnt[ch] === 1'b1) got = 1'b1;
    end
    req[ch] = 1'b0;
    chk("gnt_wait", 32'(got), 32'd1);
  endtask

  task automatic run_frame(input int ch, input int pm, input int cm, input bit toggle,
                           input int ed, input int es, input int ec);
    pm_in[ch*8 +: 8] = 8'(pm);
    cm_in[ch*8 +: 8] = 8'(cm);
    exp_gnt_q.push_back(ch);
    exp_done_q.push_back(exp_t'{ch, ed, es, pm, toggle ? 2 * pm - 1 : pm, ec});
    grant_one(ch);
    if (toggle) begin
      for (int i = 0; i < 200 && exp_done_q.size() != 0; i++) begin
        @(negedge clk);
        slot_en = ~slot_en;
      end
      slot_en = 1'b1;
    end
    wait_drain("frame_complete");
  endtask

  task automatic run_cfg_err(input int ch, input int pm, input int cm);
    pm_in[ch*8 +: 8] = 8'(pm);
    cm_in[ch*8 +: 8] = 8'(cm);
    exp_gnt_q.push_back(ch);
    exp_cfg_q.push_back(ch);
    grant_one(ch);
    wait_drain("cfg_err_seen");
  endtask

  initial begin
    int n;
    rst_n   = 1'b0;
    req     = 4'b0000;
    slot_en = 1'b1;
    pm_in   = '0;
    cm_in   = '0;

    // Reset values, then FLUSH to IDLE.
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_ctl", 32'({gnt, done, cfg_err, busy, cur_ch, cnt_err, sod_sof, sod_valid}), 32'd0);
    chk("rst_cnt", 32'({data_cnt, stuff_cnt}), 32'd0);
    chk("rst_pm_cm", 32'({sod_pm, sod_cm}), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("flush_busy", 32'(busy), 32'd1);
    wait_idle("flush_to_idle");

    // Round robin with all channels requesting.
    for (int c = 0; c < 4; c++) begin
      pm_in[c*8 +: 8] = 8'd4;
      cm_in[c*8 +: 8] = 8'd2;
    end
    for (int j = 0; j < 5; j++) begin
      exp_gnt_q.push_back(j % 4);
      exp_done_q.push_back(exp_t'{j % 4, 2, 2, 4, 4, 0});
    end
    req = 4'b1111;
    n = 0;
    for (int i = 0; i < 500 && n < 5; i++) begin
      @(negedge clk);
      if (gnt !== 4'b0000) n++;
    end
    req = 4'b0000;
    chk("rr_gnt_count", 32'(n), 32'd5);
    wait_drain("rr_complete");

    // Single frame, then backpressure, then cm=0 boundary.
    run_frame(1, 10, 7, 1'b0, 7, 3, 0);
    run_frame(0, 6, 6, 1'b1, 6, 0, 0);
    run_frame(2, 3, 0, 1'b0, 0, 3, 0);

    // Rejected configurations.
    run_cfg_err(2, 0, 0);
    run_cfg_err(3, 5, 9);

    // Reset in the middle of a frame.
    pm_in[0 +: 8] = 8'd20;
    cm_in[0 +: 8] = 8'd11;
    exp_gnt_q.push_back(0);
    grant_one(0);
    n = 0;
    for (int i = 0; i < 100 && n < 3; i++) begin
      @(negedge clk);
      if (sod_valid === 1'b1) n++;
    end
    chk("mid_beats_before_rst", 32'(n), 32'd3);
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_valid", 32'(sod_valid), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    wait_idle("mid_flush_to_idle");
    run_frame(1, 5, 2, 1'b0, 2, 3, 0);

`ifdef SOD_CNT_CHECK_EN
    force_bad = 1'b1;
    run_frame(2, 4, 2, 1'b0, 1, 3, 1);
    force_bad = 1'b0;
`endif

    chk("leftover_expectations", 32'(exp_done_q.size() + exp_gnt_q.size() + exp_cfg_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
